// File: rtl/race_pkg.sv
// Shared definitions for the two-car racer.
// Holds the game-state encoding driven on the 3-bit state bus, which the physics
// engines and the HUD also decode. It also holds the winner codes and the tick
// period helper.
package race_pkg;

  // Encodings 2 and 7 are unused; the sequencer treats them as a request for IDLE.
  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StSetting   = 3'd1,
    StCountdown = 3'd3,
    StRacing    = 3'd4,
    StPause     = 3'd5,
    StFinish    = 3'd6
  } race_state_e;

  localparam logic [1:0] WinNone = 2'd0;
  localparam logic [1:0] WinCar1 = 2'd1;
  localparam logic [1:0] WinCar2 = 2'd2;
  localparam logic [1:0] WinTie  = 2'd3;

  // Clocks per game tick. The rates are chosen to divide exactly.
  function automatic int unsigned tick_limit(input int unsigned clk_freq,
                                             input int unsigned tick_rate);
    return clk_freq / tick_rate;
  endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Free-running game tick generator.
// It counts 0..CLK_FREQ/TICK_RATE-1 and pulses tick for one clock at terminal count.
// Only rst clears it; the count runs in every game state.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   tick - 1-cycle pulse once per tick period
module game_tick_gen
  import race_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned TICK_RATE = 120
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned Limit = tick_limit(CLK_FREQ, TICK_RATE);
  localparam int unsigned CntW  = (Limit > 1) ? $clog2(Limit) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Limit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CntMax);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/race_sequencer.sv
// Game-flow controller for the two-car racer.
// It sequences IDLE -> SETTING -> COUNTDOWN -> RACING <-> PAUSE -> FINISH. It also
// runs the pre-race countdown, the race timer and the FINISH hold timer from the
// game tick, and it picks the winner from the engines' finish flags.
// Ports:
//   clk, rst                        - system clock, synchronous active-high reset
//   start_btn/pause_btn/abort_btn   - debounced levels; rising edge is the command
//   p1_ready, p2_ready              - both high ends SETTING
//   p1_finish, p2_finish            - sticky finish flags from the physics engines
//   state                           - shared 3-bit game-state bus
//   countdown                       - remaining countdown seconds (0 outside COUNTDOWN)
//   race_sec, race_tick             - elapsed race time, seconds + ticks in second
//   winner                          - 0 none, 1 car1, 2 car2, 3 tie
// All outputs are registered.
module race_sequencer
  import race_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 100_000_000,
  parameter int unsigned TICK_RATE       = 120,
  parameter int unsigned COUNTDOWN_SEC   = 3,
  parameter int unsigned FINISH_HOLD_SEC = 5,
  parameter int unsigned MAX_SEC         = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       abort_btn,
  input  logic       p1_ready,
  input  logic       p2_ready,
  input  logic       p1_finish,
  input  logic       p2_finish,
  output logic [2:0] state,
  output logic [1:0] countdown,
  output logic [9:0] race_sec,
  output logic [6:0] race_tick,
  output logic [1:0] winner
);

  localparam int unsigned HoldTicks = FINISH_HOLD_SEC * TICK_RATE;
  localparam int unsigned HoldW     = $clog2(HoldTicks + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HoldTicks - 1);
  localparam logic [6:0] TickMax = 7'(TICK_RATE - 1);
  localparam logic [9:0] SecMax  = 10'(MAX_SEC);
  localparam logic [1:0] CdStart = 2'(COUNTDOWN_SEC);

  logic tick;

  game_tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .TICK_RATE(TICK_RATE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Button edge detection, bit order {abort, pause, start}.
  logic [2:0] btn_raw, btn_q, btn_d, btn_prev_q, btn_prev_d;
  logic       start_pulse, pause_pulse, abort_pulse;

  assign btn_raw = {abort_btn, pause_btn, start_btn};

  always_comb begin
    btn_d      = btn_raw;
    btn_prev_d = btn_q;
  end

  // During reset both stages track the live level. A button held through reset
  // then shows no edge when reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q      <= btn_raw;
      btn_prev_q <= btn_raw;
    end else begin
      btn_q      <= btn_d;
      btn_prev_q <= btn_prev_d;
    end
  end

  assign start_pulse = btn_q[0] & ~btn_prev_q[0];
  assign pause_pulse = btn_q[1] & ~btn_prev_q[1];
  assign abort_pulse = btn_q[2] & ~btn_prev_q[2];

  // Game FSM and timers.
  race_state_e      state_q, state_d;
  logic [1:0]       countdown_q, countdown_d;
  logic [9:0]       race_sec_q, race_sec_d;
  logic [6:0]       race_tick_q, race_tick_d;
  logic [1:0]       winner_q, winner_d;
  logic [6:0]       cd_sub_q, cd_sub_d;
  logic [HoldW-1:0] hold_q, hold_d;

  always_comb begin
    state_d     = state_q;
    countdown_d = countdown_q;
    race_sec_d  = race_sec_q;
    race_tick_d = race_tick_q;
    winner_d    = winner_q;
    cd_sub_d    = cd_sub_q;
    hold_d      = hold_q;

    if (abort_pulse) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_pulse) state_d = StSetting;
        end
        StSetting: begin
          if (p1_ready && p2_ready) begin
            state_d     = StCountdown;
            countdown_d = CdStart;
            cd_sub_d    = '0;
          end
        end
        StCountdown: begin
          if (tick) begin
            if (cd_sub_q == TickMax) begin
              cd_sub_d    = '0;
              countdown_d = countdown_q - 2'd1;
              if (countdown_q == 2'd1) state_d = StRacing;
            end else begin
              cd_sub_d = cd_sub_q + 7'd1;
            end
          end
        end
        StRacing: begin
          if (tick) begin
            if (race_tick_q == TickMax) begin
              race_tick_d = '0;
              if (race_sec_q != SecMax) race_sec_d = race_sec_q + 10'd1;
            end else begin
              race_tick_d = race_tick_q + 7'd1;
            end
          end
          // Finish wins over a pause requested in the same clock.
          if (p1_finish || p2_finish) begin
            state_d  = StFinish;
            winner_d = {p2_finish, p1_finish};
            hold_d   = '0;
          end else if (pause_pulse) begin
            state_d = StPause;
          end
        end
        StPause: begin
          if (pause_pulse) state_d = StRacing;
        end
        StFinish: begin
          if (start_pulse) begin
            state_d = StIdle;
          end else if (tick) begin
            if (hold_q == HoldMax) begin
              state_d = StIdle;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Every path into IDLE clears the displayed values and the internal timers,
    // so the HUD shows zeros from the first IDLE cycle.
    if (state_d == StIdle) begin
      countdown_d = '0;
      race_sec_d  = '0;
      race_tick_d = '0;
      winner_d    = WinNone;
      cd_sub_d    = '0;
      hold_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      countdown_q <= '0;
      race_sec_q  <= '0;
      race_tick_q <= '0;
      winner_q    <= WinNone;
      cd_sub_q    <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      countdown_q <= countdown_d;
      race_sec_q  <= race_sec_d;
      race_tick_q <= race_tick_d;
      winner_q    <= winner_d;
      cd_sub_q    <= cd_sub_d;
      hold_q      <= hold_d;
    end
  end

  assign state     = state_q;
  assign countdown = countdown_q;
  assign race_sec  = race_sec_q;
  assign race_tick = race_tick_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_race_sequencer.sv
// Self-checking bench for race_sequencer.
// The main instance uses CLK_FREQ=1200 and TICK_RATE=120, so 1 tick is 10 clocks.
// Expected state transitions, with the clock cycle they must happen on, are queued
// when the stimulus is driven. They are compared when the state bus changes.
// A second instance has a short tick and MAX_SEC=4 so that race-second saturation
// can be reached quickly.
module tb_race_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn, pause_btn, abort_btn;
  logic       p1_ready, p2_ready, p1_finish, p2_finish;
  logic [2:0] state;
  logic [1:0] countdown;
  logic [9:0] race_sec;
  logic [6:0] race_tick;
  logic [1:0] winner;

  logic       s_start_btn, s_pause_btn, s_abort_btn;
  logic       s_p1_ready, s_p2_ready, s_p1_finish, s_p2_finish;
  logic [2:0] s_state;
  logic [1:0] s_countdown;
  logic [9:0] s_race_sec;
  logic [6:0] s_race_tick;
  logic [1:0] s_winner;

  race_sequencer #(
    .CLK_FREQ       (1200),
    .TICK_RATE      (120),
    .COUNTDOWN_SEC  (3),
    .FINISH_HOLD_SEC(5),
    .MAX_SEC        (999)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start_btn(start_btn),
    .pause_btn(pause_btn),
    .abort_btn(abort_btn),
    .p1_ready (p1_ready),
    .p2_ready (p2_ready),
    .p1_finish(p1_finish),
    .p2_finish(p2_finish),
    .state    (state),
    .countdown(countdown),
    .race_sec (race_sec),
    .race_tick(race_tick),
    .winner   (winner)
  );

  race_sequencer #(
    .CLK_FREQ       (240),
    .TICK_RATE      (120),
    .COUNTDOWN_SEC  (1),
    .FINISH_HOLD_SEC(1),
    .MAX_SEC        (4)
  ) u_dut_sat (
    .clk      (clk),
    .rst      (rst),
    .start_btn(s_start_btn),
    .pause_btn(s_pause_btn),
    .abort_btn(s_abort_btn),
    .p1_ready (s_p1_ready),
    .p2_ready (s_p2_ready),
    .p1_finish(s_p1_finish),
    .p2_finish(s_p2_finish),
    .state    (s_state),
    .countdown(s_countdown),
    .race_sec (s_race_sec),
    .race_tick(s_race_tick),
    .winner   (s_winner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;    // posedges seen so far
  int phase = 0;  // expected value of the free-running tick counter (period 10)

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) phase <= 0;
    else     phase <= (phase == 9) ? 0 : phase + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    string tag;
    int    st;
    int    cd;
    int    sec;
    int    tk;
    int    win;
    int    c;   // cycle of the transition, -1 when not pinned
  } exp_t;

  exp_t exp_q[$];

  task automatic push_exp(input string tag, input int st, input int cd, input int sec,
                          input int tk, input int win, input int c);
    exp_t e;
    e.tag = tag; e.st = st; e.cd = cd; e.sec = sec; e.tk = tk; e.win = win; e.c = c;
    exp_q.push_back(e);
  endtask

  // Transition monitor: every change of the state bus must match the next queued entry.
  logic [2:0] prev_state = 3'd0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_state = 3'd0;
    end else if (state !== prev_state) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_transition", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check({e.tag, "_state"}, 32'(state), e.st);
        check({e.tag, "_countdown"}, 32'(countdown), e.cd);
        check({e.tag, "_race_sec"}, 32'(race_sec), e.sec);
        check({e.tag, "_race_tick"}, 32'(race_tick), e.tk);
        check({e.tag, "_winner"}, 32'(winner), e.win);
        if (e.c >= 0) check({e.tag, "_cycle"}, cyc, e.c);
      end
      prev_state = state;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Return just after an edge such that the next edge carries a tick.
  task automatic align_tick();
    while (phase != 9) wait_cycles(1);
  endtask

  task automatic press(input int which);
    case (which)
      0: start_btn = 1'b1;
      1: pause_btn = 1'b1;
      default: abort_btn = 1'b1;
    endcase
    wait_cycles(3);
    start_btn = 1'b0;
    pause_btn = 1'b0;
    abort_btn = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    int n = 0;
    while (state !== st && n < budget) begin
      wait_cycles(1);
      n++;
    end
    if (state !== st) check({tag, "_timeout"}, 32'(state), 32'(st));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    start_btn = 1'b1;  // held across reset release
    pause_btn = 1'b0; abort_btn = 1'b0;
    p1_ready = 1'b0; p2_ready = 1'b0; p1_finish = 1'b0; p2_finish = 1'b0;
    s_start_btn = 1'b0; s_pause_btn = 1'b0; s_abort_btn = 1'b0;
    s_p1_ready = 1'b1; s_p2_ready = 1'b1; s_p1_finish = 1'b0; s_p2_finish = 1'b0;

    // Reset and idle.
    wait_cycles(3);
    check("rst_state", 32'(state), 0);
    check("rst_countdown", 32'(countdown), 0);
    check("rst_race_sec", 32'(race_sec), 0);
    check("rst_race_tick", 32'(race_tick), 0);
    check("rst_winner", 32'(winner), 0);
    rst = 1'b0;
    wait_cycles(5);
    check("start_held_no_pulse", 32'(state), 0);
    start_btn = 1'b0;
    wait_cycles(3);

    // Race 1: full flow, pause, finish by car 2, timed return to IDLE.
    push_exp("r1_setting", 1, 0, 0, 0, 0, cyc + 2);
    press(0);
    align_tick();
    p1_ready = 1'b1; p2_ready = 1'b1;
    push_exp("r1_countdown", 3, 3, 0, 0, 0, cyc + 1);
    push_exp("r1_racing", 4, 0, 0, 0, 0, cyc + 3601);
    wait_cycles(1);
    check("r1_cd3_start", 32'(countdown), 3);
    wait_cycles(1199);
    check("r1_cd3_end", 32'(countdown), 3);
    wait_cycles(1);
    check("r1_cd2", 32'(countdown), 2);
    wait_cycles(1200);
    check("r1_cd1", 32'(countdown), 1);
    wait_cycles(1199);
    check("r1_cd_last_cycle", 32'(state), 3);
    wait_cycles(1);
    p1_ready = 1'b0; p2_ready = 1'b0;
    wait_cycles(3000);
    push_exp("r1_pause", 5, 0, 2, 60, 0, cyc + 2);
    press(1);
    wait_cycles(100);
    p1_finish = 1'b1;  // ignored while paused
    wait_cycles(100);
    p1_finish = 1'b0;
    wait_cycles(4800);
    check("r1_pause_state", 32'(state), 5);
    check("r1_pause_sec", 32'(race_sec), 2);
    check("r1_pause_tick", 32'(race_tick), 60);
    push_exp("r1_resume", 4, 0, 2, 60, 0, cyc + 2);
    press(1);
    wait_cycles(599);
    check("r1_sec3", 32'(race_sec), 3);
    check("r1_tick0", 32'(race_tick), 0);
    align_tick();
    p2_finish = 1'b1;
    push_exp("r1_finish", 6, 0, 3, 1, 2, cyc + 1);
    push_exp("r1_hold_idle", 0, 0, 0, 0, 0, cyc + 6001);
    wait_cycles(3001);
    check("r1_fin_winner", 32'(winner), 2);
    check("r1_fin_sec", 32'(race_sec), 3);
    check("r1_fin_tick", 32'(race_tick), 1);
    wait_cycles(2999);
    check("r1_hold_not_done", 32'(state), 6);
    wait_cycles(1);
    check("r1_hold_done", 32'(state), 0);
    check("r1_idle_winner", 32'(winner), 0);
    p2_finish = 1'b0;
    wait_cycles(5);

    // Race 2: tie, then start leaves FINISH at once.
    push_exp("r2_setting", 1, 0, 0, 0, 0, cyc + 2);
    push_exp("r2_countdown", 3, 3, 0, 0, 0, cyc + 4);
    push_exp("r2_racing", 4, 0, 0, 0, 0, -1);
    press(0);
    p1_ready = 1'b1; p2_ready = 1'b1;
    wait_state("r2_racing", 3'd4, 4000);
    wait_cycles(50);
    p1_finish = 1'b1; p2_finish = 1'b1;
    push_exp("r2_tie", 6, 0, 0, 5, 3, cyc + 1);
    wait_cycles(10);
    push_exp("r2_start_exit", 0, 0, 0, 0, 0, cyc + 2);
    press(0);
    p1_finish = 1'b0; p2_finish = 1'b0;
    wait_cycles(5);

    // Race 3: pause pulse in the same clock as p1_finish, then abort from FINISH.
    push_exp("r3_setting", 1, 0, 0, 0, 0, cyc + 2);
    push_exp("r3_countdown", 3, 3, 0, 0, 0, cyc + 3);
    push_exp("r3_racing", 4, 0, 0, 0, 0, -1);
    press(0);
    wait_state("r3_racing", 3'd4, 4000);
    wait_cycles(20);
    pause_btn = 1'b1;
    push_exp("r3_finish", 6, 0, 0, 2, 1, cyc + 2);
    wait_cycles(1);
    p1_finish = 1'b1;
    wait_cycles(2);
    pause_btn = 1'b0;
    wait_cycles(20);
    push_exp("r3_abort", 0, 0, 0, 0, 0, cyc + 2);
    press(2);
    p1_finish = 1'b0;
    wait_cycles(5);

    // Race 4: pause ignored in COUNTDOWN, abort clears countdown.
    push_exp("r4_setting", 1, 0, 0, 0, 0, cyc + 2);
    push_exp("r4_countdown", 3, 3, 0, 0, 0, cyc + 3);
    press(0);
    press(1);
    wait_cycles(97);
    check("r4_pause_ignored", 32'(state), 3);
    check("r4_cd_before_abort", 32'(countdown), 3);
    push_exp("r4_abort", 0, 0, 0, 0, 0, cyc + 2);
    press(2);
    check("r4_cd_after_abort", 32'(countdown), 0);
    p1_ready = 1'b0; p2_ready = 1'b0;
    wait_cycles(5);

    // Saturation instance: 1 s = 240 clocks, MAX_SEC = 4.
    s_start_btn = 1'b1;
    wait_cycles(3);
    s_start_btn = 1'b0;
    n = 0;
    while (s_state !== 3'd4 && n < 2000) begin
      wait_cycles(1);
      n++;
    end
    check("sat_enter_racing", 32'(s_state), 4);
    wait_cycles(960);
    check("sat_sec_at_max", 32'(s_race_sec), 4);
    check("sat_tick_at_max", 32'(s_race_tick), 0);
    wait_cycles(480);
    check("sat_sec_held", 32'(s_race_sec), 4);
    check("sat_tick_wrapped", 32'(s_race_tick), 0);
    wait_cycles(120);
    check("sat_tick_runs", 32'(s_race_tick), 60);
    check("sat_sec_still", 32'(s_race_sec), 4);

    check("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
